// File: rtl/flashram_pkg.sv
// Shared FlashRAM definitions: command opcodes, engine states, status-word layout.
package flashram_pkg;

  localparam logic [7:0] CMD_READ         = 8'hF0;
  localparam logic [7:0] CMD_STATUS       = 8'hE1;
  localparam logic [7:0] CMD_ERASE_SECTOR = 8'h4B;
  localparam logic [7:0] CMD_ERASE_CHIP   = 8'h3C;
  localparam logic [7:0] CMD_ERASE_START  = 8'hD2;
  localparam logic [7:0] CMD_BUFFER       = 8'hB4;
  localparam logic [7:0] CMD_PROGRAM      = 8'hA5;

  typedef enum logic [2:0] {
    ST_READ,
    ST_STATUS,
    ST_ERASE_ARMED,
    ST_BUFFER,
    ST_BUSY
  } e_flashram_state;

  localparam int STATUS_WRITE_BUSY = 0;
  localparam int STATUS_ERASE_BUSY = 1;
  localparam int STATUS_WRITE_DONE = 2;
  localparam int STATUS_ERASE_DONE = 3;

  function automatic logic [31:0] status_word(
    input logic [23:0] id_hi,
    input logic        erase_done,
    input logic        write_done,
    input logic        erase_busy,
    input logic        write_busy
  );
    logic [31:0] w;
    w = {id_hi, 8'h00};
    w[STATUS_ERASE_DONE] = erase_done;
    w[STATUS_WRITE_DONE] = write_done;
    w[STATUS_ERASE_BUSY] = erase_busy;
    w[STATUS_WRITE_BUSY] = write_busy;
    return w;
  endfunction

endpackage

// File: rtl/flashram_page_buffer.sv
// 32x32 program page buffer: N64 write port, CPU read port with 1-cycle latency.
// Never stalls; contents survive reset.
module flashram_page_buffer (
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr,
  output logic [31:0] o_rdata
);

  logic [31:0] r_mem [32];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/n64_flashram.sv
// N64 FlashRAM command engine: decodes commands, holds the page buffer, hands erase/program to firmware.
// Every N64 access acked exactly one cycle later, no backpressure; firmware completes via operation_done.
module n64_flashram
  import flashram_pkg::*;
#(
  parameter logic [23:0] ID_HI = 24'h111180
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_n64_request,
  input  logic        i_n64_write,
  input  logic [16:0] i_n64_address,
  input  logic [31:0] i_n64_wdata,
  output logic [31:0] o_n64_rdata,
  output logic        o_n64_ack,
  output logic        o_read_mode,
  input  logic [4:0]  i_flashram_address,
  output logic [31:0] o_flashram_rdata,
  output logic [9:0]  o_flashram_sector,
  output logic        o_flashram_operation_pending,
  output logic        o_flashram_write_or_erase,
  output logic        o_flashram_sector_or_all,
  input  logic        i_flashram_operation_done
);

  e_flashram_state r_state;
  e_flashram_state w_next_state;

  logic        r_pending;
  logic        r_write_or_erase;
  logic        r_sector_or_all;
  logic        r_erase_done;
  logic        r_write_done;
  logic [9:0]  r_sector;
  logic        r_ack;
  logic [31:0] r_rdata;

  logic [7:0]  w_opcode;
  logic        w_cmd_wr;
  logic        w_reg_rd;
  logic        w_busy;
  logic        w_done;
  logic        w_buf_we;
  logic        w_read_mode;
  logic        w_unused;

  assign w_opcode = i_n64_wdata[31:24];
  assign w_cmd_wr = i_n64_request & i_n64_write & i_n64_address[16];
  assign w_reg_rd = i_n64_request & ~i_n64_write & i_n64_address[16];
  assign w_busy   = (r_state == ST_BUSY);
  assign w_done   = w_busy & i_flashram_operation_done;
  assign w_unused = ^{i_n64_address[15:7], i_n64_address[1:0], i_n64_wdata[23:10]};

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_READ;
    else         r_state <= w_next_state;
  end

  // BUSY only leaves on completion; any command arriving alongside it is dropped.
  always_comb begin
    w_next_state = r_state;
    if (w_busy) begin
      if (i_flashram_operation_done) w_next_state = ST_STATUS;
    end else if (w_cmd_wr) begin
      case (w_opcode)
        CMD_READ:         w_next_state = ST_READ;
        CMD_STATUS:       w_next_state = ST_STATUS;
        CMD_ERASE_SECTOR: w_next_state = ST_ERASE_ARMED;
        CMD_ERASE_CHIP:   w_next_state = ST_ERASE_ARMED;
        CMD_ERASE_START:  if (r_state == ST_ERASE_ARMED) w_next_state = ST_BUSY;
        CMD_BUFFER:       w_next_state = ST_BUFFER;
        CMD_PROGRAM:      w_next_state = ST_BUSY;
        default:          w_next_state = r_state;
      endcase
    end
  end

  always_comb begin
    w_read_mode = (r_state == ST_READ);
    w_buf_we    = (r_state == ST_BUFFER) & i_n64_request & i_n64_write & ~i_n64_address[16];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending        <= 1'b0;
      r_write_or_erase <= 1'b0;
      r_sector_or_all  <= 1'b0;
      r_erase_done     <= 1'b0;
      r_write_done     <= 1'b0;
      r_sector         <= '0;
    end else if (w_done) begin
      r_pending <= 1'b0;
      if (r_write_or_erase) r_write_done <= 1'b1;
      else                  r_erase_done <= 1'b1;
    end else if (w_cmd_wr && !w_busy) begin
      case (w_opcode)
        CMD_ERASE_SECTOR: begin
          r_sector        <= i_n64_wdata[9:0];
          r_sector_or_all <= 1'b0;
        end
        CMD_ERASE_CHIP: begin
          r_sector        <= '0;
          r_sector_or_all <= 1'b1;
        end
        CMD_ERASE_START: begin
          if (r_state == ST_ERASE_ARMED) begin
            r_write_or_erase <= 1'b0;
            r_pending        <= 1'b1;
            r_erase_done     <= 1'b0;
          end
        end
        CMD_PROGRAM: begin
          r_sector         <= i_n64_wdata[9:0];
          r_sector_or_all  <= 1'b0;
          r_write_or_erase <= 1'b1;
          r_pending        <= 1'b1;
          r_write_done     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Data-region reads return zero; only the register read carries the status word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= i_n64_request;
      r_rdata <= w_reg_rd ? status_word(ID_HI, r_erase_done, r_write_done,
                                        r_pending & ~r_write_or_erase,
                                        r_pending & r_write_or_erase) : '0;
    end
  end

  flashram_page_buffer u_page_buffer (
    .i_clk   (i_clk),
    .i_we    (w_buf_we),
    .i_waddr (i_n64_address[6:2]),
    .i_wdata (i_n64_wdata),
    .i_raddr (i_flashram_address),
    .o_rdata (o_flashram_rdata)
  );

  assign o_n64_rdata                  = r_rdata;
  assign o_n64_ack                    = r_ack;
  assign o_read_mode                  = w_read_mode;
  assign o_flashram_sector            = r_sector;
  assign o_flashram_operation_pending = r_pending;
  assign o_flashram_write_or_erase    = r_write_or_erase;
  assign o_flashram_sector_or_all     = r_sector_or_all;

endmodule

// File: tb/tb_n64_flashram.sv
// Scenario bench for n64_flashram: expected N64 read data queued at request, popped at ack.
module tb_n64_flashram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        write = 1'b0;
  logic [16:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] n64_rdata;
  logic        ack;
  logic        read_mode;
  logic [4:0]  cpu_addr = '0;
  logic [31:0] cpu_rdata;
  logic [9:0]  sector;
  logic        pending;
  logic        woe;
  logic        soa;
  logic        op_done = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] buf_model[32];

  always #5 clk = ~clk;

  n64_flashram dut (
    .i_clk                        (clk),
    .i_reset                      (reset),
    .i_n64_request                (req),
    .i_n64_write                  (write),
    .i_n64_address                (address),
    .i_n64_wdata                  (wdata),
    .o_n64_rdata                  (n64_rdata),
    .o_n64_ack                    (ack),
    .o_read_mode                  (read_mode),
    .i_flashram_address           (cpu_addr),
    .o_flashram_rdata             (cpu_rdata),
    .o_flashram_sector            (sector),
    .o_flashram_operation_pending (pending),
    .o_flashram_write_or_erase    (woe),
    .o_flashram_sector_or_all     (soa),
    .i_flashram_operation_done    (op_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic n64_drive(input logic wr, input logic [16:0] a, input logic [31:0] d);
    req = 1'b1; write = wr; address = a; wdata = d;
    tick();
    req = 1'b0; write = 1'b0;
  endtask

  task automatic cmd(input logic [31:0] d);
    n64_drive(1'b1, 17'h10000, d);
  endtask

  task automatic status_read(input logic [31:0] e);
    exp_q.push_back(e);
    n64_drive(1'b0, 17'h10000, 32'h0);
  endtask

  task automatic pulse_done();
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    do_reset();
    tests++;
    if (read_mode !== 1'b1 || pending !== 1'b0 || woe !== 1'b0 || soa !== 1'b0 ||
        sector !== 10'h0 || ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: rm=%b pend=%b woe=%b soa=%b sec=%h ack=%b, want rm=1 others 0",
               read_mode, pending, woe, soa, sector, ack);
    end
    status_read(32'h1111_8000);
    e = exp_q.pop_front();
    tests++;
    if (ack !== 1'b1 || n64_rdata !== e) begin
      fails++;
      $display("FAIL reset_status: ack=%b rdata=%h, want ack=1 rdata=%h", ack, n64_rdata, e);
    end
    tick();
    tests++;
    if (ack !== 1'b0 || n64_rdata !== 32'h0) begin
      fails++;
      $display("FAIL ack_idle: ack=%b rdata=%h, want 0/0", ack, n64_rdata);
    end
  endtask

  task automatic test_program();
    logic [31:0] e;
    cmd(32'hB400_0000);
    for (int i = 0; i < 32; i++) begin
      n64_drive(1'b1, 17'(i * 4), 32'hA5A5_0000 + 32'(i));
      buf_model[i] = 32'hA5A5_0000 + 32'(i);
    end
    cmd(32'hA500_0123);
    tests++;
    if (sector !== 10'h123 || woe !== 1'b1 || pending !== 1'b1 || soa !== 1'b0 || read_mode !== 1'b0) begin
      fails++;
      $display("FAIL program_flags: sec=%h woe=%b pend=%b soa=%b rm=%b, want 123/1/1/0/0",
               sector, woe, pending, soa, read_mode);
    end
    status_read(32'h1111_8001);
    e = exp_q.pop_front();
    tests++;
    if (ack !== 1'b1 || n64_rdata !== e) begin
      fails++;
      $display("FAIL program_busy_status: ack=%b rdata=%h, want ack=1 rdata=%h", ack, n64_rdata, e);
    end
    for (int i = 0; i < 32; i++) begin
      cpu_addr = 5'(i);
      tick();
      tests++;
      if (cpu_rdata !== buf_model[i]) begin
        fails++;
        $display("FAIL cpu_buf_read[%0d]: got %h, want %h", i, cpu_rdata, buf_model[i]);
      end
    end
  endtask

  task automatic test_done();
    logic [31:0] e;
    pulse_done();
    tests++;
    if (pending !== 1'b0 || woe !== 1'b1 || sector !== 10'h123 || read_mode !== 1'b0) begin
      fails++;
      $display("FAIL done_flags: pend=%b woe=%b sec=%h rm=%b, want 0/1/123/0", pending, woe, sector, read_mode);
    end
    status_read(32'h1111_8004);
    e = exp_q.pop_front();
    tests++;
    if (ack !== 1'b1 || n64_rdata !== e) begin
      fails++;
      $display("FAIL done_status: ack=%b rdata=%h, want ack=1 rdata=%h", ack, n64_rdata, e);
    end
    n64_drive(1'b1, 17'h00000, 32'h1234_5678);
    cpu_addr = 5'd0;
    tick();
    tests++;
    if (cpu_rdata !== buf_model[0]) begin
      fails++;
      $display("FAIL status_buf_write_ignored: got %h, want %h", cpu_rdata, buf_model[0]);
    end
  endtask

  task automatic test_erase();
    logic [31:0] e;
    do_reset();
    cmd(32'h4B00_0080);
    tests++;
    if (sector !== 10'h080 || soa !== 1'b0 || pending !== 1'b0 || read_mode !== 1'b0) begin
      fails++;
      $display("FAIL erase_armed: sec=%h soa=%b pend=%b rm=%b, want 080/0/0/0", sector, soa, pending, read_mode);
    end
    cmd(32'hD200_0000);
    tests++;
    if (pending !== 1'b1 || woe !== 1'b0 || sector !== 10'h080 || soa !== 1'b0) begin
      fails++;
      $display("FAIL erase_start: pend=%b woe=%b sec=%h soa=%b, want 1/0/080/0", pending, woe, sector, soa);
    end
    status_read(32'h1111_8002);
    e = exp_q.pop_front();
    tests++;
    if (ack !== 1'b1 || n64_rdata !== e) begin
      fails++;
      $display("FAIL erase_busy_status: ack=%b rdata=%h, want ack=1 rdata=%h", ack, n64_rdata, e);
    end
    cmd(32'hB400_0000);
    n64_drive(1'b1, 17'h00014, 32'hDEAD_BEEF);
    cmd(32'hA500_0155);
    cpu_addr = 5'd5;
    tick();
    tests++;
    if (cpu_rdata !== buf_model[5] || pending !== 1'b1 || woe !== 1'b0 || sector !== 10'h080) begin
      fails++;
      $display("FAIL busy_ignores_cmds: buf=%h pend=%b woe=%b sec=%h, want %h/1/0/080",
               cpu_rdata, pending, woe, sector, buf_model[5]);
    end
    pulse_done();
    status_read(32'h1111_8008);
    e = exp_q.pop_front();
    tests++;
    if (ack !== 1'b1 || n64_rdata !== e || pending !== 1'b0) begin
      fails++;
      $display("FAIL erase_done_status: ack=%b rdata=%h pend=%b, want 1/%h/0", ack, n64_rdata, pending, e);
    end
  endtask

  task automatic test_chip_erase_same_cycle();
    logic [31:0] e;
    cmd(32'h3C00_0000);
    tests++;
    if (sector !== 10'h0 || soa !== 1'b1) begin
      fails++;
      $display("FAIL chip_armed: sec=%h soa=%b, want 000/1", sector, soa);
    end
    cmd(32'hD200_0000);
    op_done = 1'b1;
    cmd(32'hF000_0000);
    op_done = 1'b0;
    tests++;
    if (pending !== 1'b0 || read_mode !== 1'b0 || soa !== 1'b1 || ack !== 1'b1) begin
      fails++;
      $display("FAIL done_with_cmd: pend=%b rm=%b soa=%b ack=%b, want 0/0/1/1", pending, read_mode, soa, ack);
    end
    status_read(32'h1111_8008);
    e = exp_q.pop_front();
    tests++;
    if (ack !== 1'b1 || n64_rdata !== e) begin
      fails++;
      $display("FAIL chip_done_status: ack=%b rdata=%h, want ack=1 rdata=%h", ack, n64_rdata, e);
    end
  endtask

  task automatic test_reset_busy();
    logic [31:0] e;
    cmd(32'hD200_0000);
    tests++;
    if (pending !== 1'b0) begin
      fails++;
      $display("FAIL d2_unarmed: pend=%b, want 0", pending);
    end
    cmd(32'hA500_0001);
    reset = 1'b1;
    tick();
    tests++;
    if (pending !== 1'b0 || read_mode !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_busy: pend=%b rm=%b, want 0/1", pending, read_mode);
    end
    reset = 1'b0;
    pulse_done();
    status_read(32'h1111_8000);
    e = exp_q.pop_front();
    tests++;
    if (n64_rdata !== e || pending !== 1'b0 || read_mode !== 1'b1) begin
      fails++;
      $display("FAIL late_done: rdata=%h pend=%b rm=%b, want %h/0/1", n64_rdata, pending, read_mode, e);
    end
  endtask

  task automatic test_back_to_back();
    logic        wr_t[5];
    logic [16:0] ad_t[5];
    logic [31:0] dt_t[5];
    logic [31:0] ex_t[5];
    logic [31:0] e;
    do_reset();
    wr_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ad_t = '{17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h00004};
    dt_t = '{32'h0, 32'hE100_0000, 32'h0, 32'h7700_0000, 32'h0};
    ex_t = '{32'h1111_8000, 32'h0, 32'h1111_8000, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      req = 1'b1; write = wr_t[i]; address = ad_t[i]; wdata = dt_t[i];
      exp_q.push_back(ex_t[i]);
      tick();
      e = exp_q.pop_front();
      tests++;
      if (ack !== 1'b1 || n64_rdata !== e) begin
        fails++;
        $display("FAIL b2b_access[%0d]: ack=%b rdata=%h, want ack=1 rdata=%h", i, ack, n64_rdata, e);
      end
    end
    req = 1'b0; write = 1'b0;
    tick();
    tests++;
    if (ack !== 1'b0 || read_mode !== 1'b0 || pending !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_tail: ack=%b rm=%b pend=%b q=%0d, want 0/0/0/0", ack, read_mode, pending, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_program();
    test_done();
    test_erase();
    test_chip_erase_same_cycle();
    test_reset_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
